if_id_skid: RTL and testbench

IF_ID_SKID -- requirements
Module: if_id_skid

---
 rtl/if_id_skid_pkg.sv | 14 +
 rtl/if_id_skid.sv | 82 ++++++++
 tb/tb_if_id_skid.sv | 137 +++++++++++++
 3 files changed

// File: rtl/if_id_skid_pkg.sv
// Shared pipeline constants for the IF/ID skid buffer (mirrors the core's define.v)
// plus the 2-bit fill-count encoding.
package if_id_skid_pkg;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [1:0]  CNT_EMPTY   = 2'd0;
    localparam logic [1:0]  CNT_ONE     = 2'd1;
    localparam logic [1:0]  CNT_TWO     = 2'd2;
endpackage

// File: rtl/if_id_skid.sv
// IF/ID boundary: 2-entry skid FIFO between fetch and decode, head held in registers.
// pc_wd never credits a same-cycle pop, so the fetch already in flight always has a slot.
module if_id_skid
    import if_id_skid_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   ifid_wd,
    input  logic [InstAddrBus-1:0] if_pc,
    input  logic [InstBus-1:0]     if_inst,
    output logic                   pc_wd,
    input  logic                   flush,
    input  logic                   id_stall,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    output logic                   id_valid,
    output logic                   ovf
);
    logic [1:0]             r_cnt;
    logic [InstAddrBus-1:0] r_pc0, r_pc1;
    logic [InstBus-1:0]     r_inst0, r_inst1;
    logic                   r_ovf;

    logic       w_push, w_pop;
    logic [2:0] w_fill;

    assign id_valid = (r_cnt != CNT_EMPTY);
    assign id_pc    = r_pc0;
    assign id_inst  = r_inst0;
    assign ovf      = r_ovf;

    assign w_push = ifid_wd & (ce == ChipEnable) & ~flush;
    assign w_pop  = id_valid & ~id_stall & ~flush;
    assign w_fill = {1'b0, r_cnt} + {2'b00, ifid_wd};
    assign pc_wd  = (rst != RstEnable) & (ce != ChipDisable) & ~flush & (w_fill <= 3'd1);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_cnt   <= CNT_EMPTY;
            r_pc0   <= ZeroWord;
            r_inst0 <= ZeroWord;
            r_pc1   <= ZeroWord;
            r_inst1 <= ZeroWord;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_cnt <= CNT_EMPTY;
        end else begin
            case (r_cnt)
                CNT_EMPTY: begin
                    if (w_push) begin
                        r_pc0   <= if_pc;
                        r_inst0 <= if_inst;
                        r_cnt   <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (w_push && w_pop) begin
                        r_pc0   <= if_pc;
                        r_inst0 <= if_inst;
                    end else if (w_push) begin
                        r_pc1   <= if_pc;
                        r_inst1 <= if_inst;
                        r_cnt   <= CNT_TWO;
                    end else if (w_pop) begin
                        r_cnt <= CNT_EMPTY;
                    end
                end
                CNT_TWO: begin
                    if (w_pop) begin
                        r_pc0   <= r_pc1;
                        r_inst0 <= r_inst1;
                        r_cnt   <= CNT_ONE;
                    end
                    // A push here means the producer ignored pc_wd: drop it and flag.
                    if (w_push) r_ovf <= 1'b1;
                end
                default: r_cnt <= CNT_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table with constant expectations, a queue
// scoreboard for decode order, and a random phase with a producer obeying pc_wd.
module tb_if_id_skid;
    logic        clk = 1'b0;
    logic        rst, ce, ifid_wd, flush, id_stall;
    logic [31:0] if_pc, if_inst;
    logic        pc_wd, id_valid, ovf;
    logic [31:0] id_pc, id_inst;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst, ce, wd, fl, st;
        logic [31:0] pc;
        logic        exp_pcwd, exp_vld;
        logic [31:0] exp_idpc;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];   // expected pc stream, in acceptance order

    always #5 clk = ~clk;

    if_id_skid dut (
        .clk(clk), .rst(rst), .ce(ce), .ifid_wd(ifid_wd), .if_pc(if_pc), .if_inst(if_inst),
        .pc_wd(pc_wd), .flush(flush), .id_stall(id_stall), .id_pc(id_pc), .id_inst(id_inst),
        .id_valid(id_valid), .ovf(ovf)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h3C01_1230 + pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, c, w, f, s, input logic [31:0] pc,
                                input logic epw, ev, input logic [31:0] eid, input logic eo);
        vec_t v;
        v.rst = r; v.ce = c; v.wd = w; v.fl = f; v.st = s; v.pc = pc;
        v.exp_pcwd = epw; v.exp_vld = ev; v.exp_idpc = eid; v.exp_ovf = eo;
        return v;
    endfunction

    // One clock: drive, check the pre-edge outputs and scoreboard pop, then the edge.
    task automatic drive_cycle(input logic r, c, w, f, s, input logic [31:0] pc);
        logic [31:0] exp_pc;
        rst = r; ce = c; ifid_wd = w; flush = f; id_stall = s;
        if_pc = pc; if_inst = inst_of(pc);
        #1;
        if (!r && !f && !s && sb.size() > 0) begin
            exp_pc = sb.pop_front();
            chk("sb_valid", {31'b0, id_valid}, 32'd1);
            chk("sb_pc", id_pc, exp_pc);
            chk("sb_inst", id_inst, inst_of(exp_pc));
        end
        if (r || f) sb.delete();
        else if (c && w && sb.size() < 2) sb.push_back(pc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic grant;
        rst = 1'b1; ce = 1'b1; ifid_wd = 1'b0; flush = 1'b0; id_stall = 1'b0;
        if_pc = '0; if_inst = '0;
        @(posedge clk); #1;

        //            rst ce wd fl st pc          pc_wd vld id_pc       ovf
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h00, 0, 0, 32'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 1, 0, 32'h00, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h04, 1, 1, 32'h04, 0));  // first fetch
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 1, 0, 32'h04, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h04, 1, 1, 32'h04, 0));  // stall, fill
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h08, 0, 1, 32'h04, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h00, 0, 1, 32'h04, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 0, 1, 32'h08, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 1, 0, 32'h08, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h10, 1, 1, 32'h10, 0));  // push+pop in ONE
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h14, 0, 1, 32'h14, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h00, 1, 1, 32'h14, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h18, 0, 1, 32'h14, 0));  // TWO then flush
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h20, 0, 0, 32'h14, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 1, 0, 32'h14, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h24, 1, 1, 32'h24, 0));  // overflow
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h28, 0, 1, 32'h24, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h2C, 0, 1, 32'h24, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h00, 0, 1, 32'h24, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 0, 1, 32'h28, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h00, 0, 0, 32'h00, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h30, 0, 0, 32'h00, 0));  // ce off
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h34, 1, 1, 32'h34, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 32'h00, 0, 0, 32'h00, 0));  // rst in ONE
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h38, 1, 1, 32'h38, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h00, 0, 0, 32'h38, 0));  // drain with ce off
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h00, 1, 0, 32'h38, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ce = vecs[i].ce; ifid_wd = vecs[i].wd;
            flush = vecs[i].fl; id_stall = vecs[i].st;
            #1;
            chk($sformatf("v%0d_pc_wd", i), {31'b0, pc_wd}, {31'b0, vecs[i].exp_pcwd});
            drive_cycle(vecs[i].rst, vecs[i].ce, vecs[i].wd, vecs[i].fl, vecs[i].st, vecs[i].pc);
            chk($sformatf("v%0d_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].exp_vld});
            chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].exp_idpc);
            chk($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
            if (vecs[i].rst) chk($sformatf("v%0d_rst_inst", i), id_inst, 32'h0);
            else if (vecs[i].exp_vld)
                chk($sformatf("v%0d_id_inst", i), id_inst, inst_of(vecs[i].exp_idpc));
        end

        // Random phase: producer fetches only in the cycle after a grant.
        grant = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic f, s;
            f = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 2) == 0);
            rst = 1'b0; ce = 1'b1; ifid_wd = grant; flush = f; id_stall = s;
            #1;
            grant = pc_wd;
            drive_cycle(1'b0, 1'b1, ifid_wd, f, s, 32'h1000 + 32'(n) * 4);
            chk("rnd_valid", {31'b0, id_valid}, {31'b0, (sb.size() != 0)});
            if (sb.size() != 0) chk("rnd_head", id_pc, sb[0]);
            chk("rnd_ovf", {31'b0, ovf}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
